// File: rtl/avm_burst_arbiter_if.sv
// Avalon-MM burst port bundle. The master side drives the command and write data;
// the slave side drives the stall and the read return.
interface avm_burst_arbiter_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 12
);
  logic [ADDR_W-1:0]  address;
  logic [BURST_W-1:0] burstcount;
  logic               read;
  logic               write;
  logic [DATA_W-1:0]  writedata;
  logic               waitrequest;
  logic [DATA_W-1:0]  readdata;
  logic               readdatavalid;

  modport master (output address, burstcount, read, write, writedata,
                  input  waitrequest, readdata, readdatavalid);
  modport slave  (input  address, burstcount, read, write, writedata,
                  output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/avm_burst_arbiter.sv
// Two-master to one-slave Avalon-MM burst arbiter: round-robin grant per whole burst,
// with an in-order queue of outstanding reads that steers returned data to its issuer.
module avm_burst_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_W   = 12,
  parameter int RDQ_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  avm_burst_arbiter_if.slave  m0,
  avm_burst_arbiter_if.slave  m1,
  avm_burst_arbiter_if.master s,
  output logic [1:0]          grant,
  output logic                protocol_err
);
  localparam int PTR_W = $clog2(RDQ_DEPTH);
  localparam logic [PTR_W:0]   Q_FULL = RDQ_DEPTH[PTR_W:0];
  localparam logic [BURST_W-1:0] ONE  = {{(BURST_W-1){1'b0}}, 1'b1};

  typedef enum logic {ARB, CMD} state_t;

  state_t             state_reg;
  logic [1:0]         grant_reg;
  logic               last_grant_reg;
  logic               first_reg;
  logic               wr_active_reg;
  logic [BURST_W-1:0] wr_left_reg;

  logic               q_id_mem [RDQ_DEPTH];
  logic [BURST_W-1:0] q_bc_mem [RDQ_DEPTH];
  logic [PTR_W-1:0]   q_wr_ptr_reg;
  logic [PTR_W-1:0]   q_rd_ptr_reg;
  logic [PTR_W:0]     q_count_reg;
  logic               head_loaded_reg;
  logic [BURST_W-1:0] head_rem_reg;
  logic               protocol_err_reg;

  logic               in_cmd;
  logic               sel;
  logic [1:0]         elig;
  logic               arb_win;
  logic               q_full;
  logic               q_empty;
  logic               rd_acc;
  logic               wr_acc;
  logic [BURST_W-1:0] s_bc_eff;
  logic [BURST_W-1:0] head_rem;
  logic               head_id;
  logic               rdv_hit;
  logic               pop;
  logic               cmd_done;

  assign in_cmd  = (state_reg == CMD);
  assign sel     = grant_reg[1];
  assign q_full  = (q_count_reg == Q_FULL);
  assign q_empty = (q_count_reg == '0);

  // Only the granted master reaches the slave, and only while in CMD
  assign s.address    = sel ? m1.address    : m0.address;
  assign s.burstcount = sel ? m1.burstcount : m0.burstcount;
  assign s.writedata  = sel ? m1.writedata  : m0.writedata;
  assign s.read       = in_cmd && (sel ? m1.read  : m0.read);
  assign s.write      = in_cmd && (sel ? m1.write : m0.write);

  assign m0.waitrequest = !(in_cmd && grant_reg[0]) || s.waitrequest;
  assign m1.waitrequest = !(in_cmd && grant_reg[1]) || s.waitrequest;

  assign rd_acc   = s.read  && !s.waitrequest;
  assign wr_acc   = s.write && !s.waitrequest;
  assign s_bc_eff = (s.burstcount == '0) ? ONE : s.burstcount;

  // A full read queue blocks only reads; writes stay eligible
  assign elig[0] = m0.write || (m0.read && !q_full);
  assign elig[1] = m1.write || (m1.read && !q_full);
  assign arb_win = elig[~last_grant_reg] ? ~last_grant_reg : last_grant_reg;

  always_comb begin
    cmd_done = 1'b0;
    if (in_cmd) begin
      if (first_reg && !s.read && !s.write)
        cmd_done = 1'b1;
      else if (rd_acc)
        cmd_done = 1'b1;
      else if (wr_acc)
        cmd_done = wr_active_reg ? (wr_left_reg == ONE) : (s_bc_eff == ONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ARB;
      grant_reg      <= 2'b00;
      last_grant_reg <= 1'b1;
      first_reg      <= 1'b0;
      wr_active_reg  <= 1'b0;
      wr_left_reg    <= '0;
    end else begin
      case (state_reg)
        ARB: begin
          if (elig != 2'b00) begin
            state_reg      <= CMD;
            grant_reg      <= arb_win ? 2'b10 : 2'b01;
            last_grant_reg <= arb_win;
            first_reg      <= 1'b1;
            wr_active_reg  <= 1'b0;
          end
        end
        CMD: begin
          first_reg <= 1'b0;
          if (cmd_done) begin
            state_reg     <= ARB;
            grant_reg     <= 2'b00;
            wr_active_reg <= 1'b0;
          end else if (wr_acc) begin
            // burstcount is latched on the first accepted word of a write burst
            wr_active_reg <= 1'b1;
            wr_left_reg   <= wr_active_reg ? (wr_left_reg - ONE) : (s_bc_eff - ONE);
          end
        end
        default: state_reg <= ARB;
      endcase
    end
  end

  // Read return: the queue head decides which master sees each valid word
  assign head_id  = q_id_mem[q_rd_ptr_reg];
  assign head_rem = head_loaded_reg ? head_rem_reg : q_bc_mem[q_rd_ptr_reg];
  assign rdv_hit  = s.readdatavalid && !q_empty;
  assign pop      = rdv_hit && (head_rem == ONE);

  assign m0.readdata      = s.readdata;
  assign m1.readdata      = s.readdata;
  assign m0.readdatavalid = rdv_hit && !head_id;
  assign m1.readdatavalid = rdv_hit &&  head_id;

  always_ff @(posedge clk) begin
    if (rd_acc) begin
      q_id_mem[q_wr_ptr_reg] <= sel;
      q_bc_mem[q_wr_ptr_reg] <= s_bc_eff;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_wr_ptr_reg     <= '0;
      q_rd_ptr_reg     <= '0;
      q_count_reg      <= '0;
      head_loaded_reg  <= 1'b0;
      head_rem_reg     <= '0;
      protocol_err_reg <= 1'b0;
    end else begin
      if (rd_acc)
        q_wr_ptr_reg <= q_wr_ptr_reg + 1'b1;
      if (pop)
        q_rd_ptr_reg <= q_rd_ptr_reg + 1'b1;
      case ({rd_acc, pop})
        2'b10:   q_count_reg <= q_count_reg + 1'b1;
        2'b01:   q_count_reg <= q_count_reg - 1'b1;
        default: q_count_reg <= q_count_reg;
      endcase
      if (rdv_hit) begin
        head_loaded_reg <= !pop;
        head_rem_reg    <= head_rem - ONE;
      end
      if (s.readdatavalid && q_empty)
        protocol_err_reg <= 1'b1;
    end
  end

  assign grant        = grant_reg;
  assign protocol_err = protocol_err_reg;
endmodule

// File: tb/tb_avm_burst_arbiter.sv
// Bench for avm_burst_arbiter: random two-master traffic against a transaction-level
// slave/arbitration model, followed by directed full-queue, error and reset cases.
module tb_avm_burst_arbiter;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BURST_W   = 12;
  localparam int RDQ_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  avm_burst_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) m0_bus ();
  avm_burst_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) m1_bus ();
  avm_burst_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) s_bus ();
  logic [1:0] grant;
  logic       protocol_err;

  avm_burst_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .RDQ_DEPTH(RDQ_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .m0(m0_bus), .m1(m1_bus), .s(s_bus),
    .grant(grant), .protocol_err(protocol_err)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wpat(input int n, input logic [31:0] a, input int idx);
    logic [31:0] nn;
    logic [31:0] ii;
    nn = 32'(n);
    ii = 32'(idx);
    return {nn[0], 3'b000, a[19:0], ii[7:0]};
  endfunction

  function automatic logic [31:0] rdat(input logic [31:0] a, input int idx);
    return (a ^ 32'hA500_0000) + 32'(idx);
  endfunction

  function automatic logic m_wait(input int n);
    return (n == 0) ? m0_bus.waitrequest : m1_bus.waitrequest;
  endfunction

  task automatic drive_master(input int n, input logic rd, input logic wr, input logic [31:0] a,
                              input logic [11:0] bc, input logic [31:0] wd);
    if (n == 0) begin
      m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = a;
      m0_bus.burstcount = bc; m0_bus.writedata = wd;
    end else begin
      m1_bus.read = rd; m1_bus.write = wr; m1_bus.address = a;
      m1_bus.burstcount = bc; m1_bus.writedata = wd;
    end
  endtask

  task automatic bus_idle();
    drive_master(0, 1'b0, 1'b0, 32'h0, 12'h0, 32'h0);
    drive_master(1, 1'b0, 1'b0, 32'h0, 12'h0, 32'h0);
    s_bus.waitrequest   = 1'b0;
    s_bus.readdatavalid = 1'b0;
    s_bus.readdata      = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Accepted-command monitors used by the directed cases
  int m0_rd_acc = 0;
  int m1_wr_acc = 0;
  always @(negedge clk) begin
    if (m0_bus.read && !m0_bus.waitrequest)  m0_rd_acc <= m0_rd_acc + 1;
    if (m1_bus.write && !m1_bus.waitrequest) m1_wr_acc <= m1_wr_acc + 1;
  end

  // Issue one complete command on master n; called and returns at posedge+1
  task automatic m_cmd(input int n, input logic rd, input logic [31:0] a, input int bc, output bit ok);
    int words;
    int done;
    words = rd ? 1 : ((bc == 0) ? 1 : bc);
    done  = 0;
    for (int c = 0; c < 40 && done < words; c++) begin
      drive_master(n, rd, !rd, a, 12'(bc), wpat(n, a, done));
      @(negedge clk);
      if (!m_wait(n)) done++;
      @(posedge clk);
      #1;
    end
    drive_master(n, 1'b0, 1'b0, 32'h0, 12'h0, 32'h0);
    ok = (done == words);
  endtask

  // ---------------- transaction-level model for the random phase ----------------
  typedef struct {
    logic [31:0] addr;
    int          len;
    int          owner;
  } burst_t;

  burst_t      sl_q[$];
  int          ret_idx;
  int          tb_last;
  int          cyc;
  logic [1:0]  elig_prev;
  logic [1:0]  grant_prev;
  bit          issue_en;
  bit          m_active [2];
  bit          m_is_rd [2];
  int          m_len [2];
  int          m_idx [2];
  logic [11:0] m_bc [2];
  logic [31:0] m_addr [2];
  int          issued_words [2];
  int          got_words [2];

  task automatic rand_drive();
    bit fast;
    for (int n = 0; n < 2; n++) begin
      if (!m_active[n] && issue_en && $urandom_range(0, 2) == 0) begin
        m_active[n] = 1'b1;
        m_is_rd[n]  = 1'($urandom_range(0, 1));
        m_bc[n]     = 12'($urandom_range(0, 4));
        m_len[n]    = (m_bc[n] == 12'h0) ? 1 : int'(m_bc[n]);
        m_addr[n]   = $urandom;
        m_idx[n]    = 0;
      end
      drive_master(n, m_active[n] && m_is_rd[n], m_active[n] && !m_is_rd[n],
                   m_addr[n], m_bc[n], wpat(n, m_addr[n], m_idx[n]));
    end
    s_bus.waitrequest = ($urandom_range(0, 3) == 0);
    // Alternate slow and fast return phases so the read queue regularly fills up
    fast = ((cyc % 400) >= 200);
    if (sl_q.size() > 0 && (fast ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0))) begin
      s_bus.readdatavalid = 1'b1;
      s_bus.readdata      = rdat(sl_q[0].addr, ret_idx);
    end else begin
      s_bus.readdatavalid = 1'b0;
      s_bus.readdata      = $urandom;
    end
  endtask

  task automatic rand_sample();
    logic [1:0] e;
    logic [1:0] exp_g;
    int         occ;
    int         w;
    burst_t     h;
    occ = sl_q.size();
    // Round robin: a new grant goes to the eligible master that was not served last
    if (grant_prev == 2'b00 && grant != 2'b00) begin
      if (elig_prev == 2'b00) begin
        exp_g = 2'b00;
      end else begin
        w       = elig_prev[1 - tb_last] ? (1 - tb_last) : tb_last;
        exp_g   = (w == 1) ? 2'b10 : 2'b01;
        tb_last = w;
      end
      check_val("rr_grant", 64'(grant), 64'(exp_g));
    end
    if (grant == 2'b00)
      check_val("arb_idle", 64'({m1_bus.waitrequest, m0_bus.waitrequest, s_bus.read, s_bus.write}),
                64'(4'b1100));
    else
      check_val("loser_wait", 64'(grant[0] ? m1_bus.waitrequest : m0_bus.waitrequest), 64'(1));
    for (int n = 0; n < 2; n++)
      e[n] = m_active[n] && (!m_is_rd[n] || occ < RDQ_DEPTH);
    elig_prev  = e;
    grant_prev = grant;

    if (s_bus.readdatavalid) begin
      h = sl_q[0];
      check_val("rdv_route", 64'({m1_bus.readdatavalid, m0_bus.readdatavalid}),
                64'((h.owner == 1) ? 2'b10 : 2'b01));
      check_val("rd_data", 64'((h.owner == 1) ? m1_bus.readdata : m0_bus.readdata),
                64'(rdat(h.addr, ret_idx)));
      got_words[h.owner]++;
      ret_idx++;
      if (ret_idx == h.len) begin
        void'(sl_q.pop_front());
        ret_idx = 0;
      end
    end

    for (int n = 0; n < 2; n++) begin
      if (m_active[n] && !m_wait(n)) begin
        if (m_is_rd[n]) begin
          check_val("rd_cmd", 64'({s_bus.read, s_bus.address, s_bus.burstcount}),
                    64'({1'b1, m_addr[n], m_bc[n]}));
          h.addr  = m_addr[n];
          h.len   = m_len[n];
          h.owner = n;
          sl_q.push_back(h);
          issued_words[n] += m_len[n];
          m_active[n] = 1'b0;
          $display("m%0d read  addr=%h len=%0d accepted", n, m_addr[n], m_len[n]);
        end else begin
          check_val("wr_word", 64'({s_bus.write, s_bus.writedata}),
                    64'({1'b1, wpat(n, m_addr[n], m_idx[n])}));
          m_idx[n]++;
          if (m_idx[n] == m_len[n]) begin
            m_active[n] = 1'b0;
            $display("m%0d write addr=%h len=%0d completed", n, m_addr[n], m_len[n]);
          end
        end
      end
    end
  endtask

  initial begin
    bit ok;
    bit accepted;
    int snap;
    int idx;

    // ---- reset state ----
    do_reset();
    @(negedge clk);
    check_val("reset_grant", 64'(grant), 64'(2'b00));
    check_val("reset_outputs",
              64'({m0_bus.waitrequest, m1_bus.waitrequest, s_bus.read, s_bus.write,
                   m0_bus.readdatavalid, m1_bus.readdatavalid, protocol_err}),
              64'(7'b1100000));
    @(posedge clk);
    #1;

    // ---- random traffic ----
    sl_q.delete();
    ret_idx = 0; tb_last = 1; cyc = 0;
    elig_prev = 2'b00; grant_prev = 2'b00;
    for (int n = 0; n < 2; n++) begin
      m_active[n] = 1'b0; m_is_rd[n] = 1'b0; m_len[n] = 1; m_idx[n] = 0;
      m_bc[n] = 12'h0; m_addr[n] = 32'h0; issued_words[n] = 0; got_words[n] = 0;
    end
    issue_en = 1'b1;
    rand_drive();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rand_sample();
      @(posedge clk);
      #1;
      cyc++;
      rand_drive();
    end
    issue_en = 1'b0;
    for (int c = 0; c < 3000 && (m_active[0] || m_active[1] || sl_q.size() != 0); c++) begin
      @(negedge clk);
      rand_sample();
      @(posedge clk);
      #1;
      cyc++;
      rand_drive();
    end
    bus_idle();
    check_val("drain_done", 64'({m_active[1], m_active[0], 32'(sl_q.size())}), 64'(0));
    check_val("m0_words", 64'(got_words[0]), 64'(issued_words[0]));
    check_val("m1_words", 64'(got_words[1]), 64'(issued_words[1]));
    check_val("rand_perr", 64'(protocol_err), 64'(0));

    // ---- full read queue: reads stall, writes proceed ----
    do_reset();
    for (int i = 0; i < RDQ_DEPTH; i++) begin
      m_cmd(0, 1'b1, 32'h100 + 32'(i * 16), 1, ok);
      check_val("fill_read", 64'(ok), 64'(1));
    end
    drive_master(0, 1'b1, 1'b0, 32'h200, 12'h1, 32'h0);
    snap = m0_rd_acc;
    m_cmd(1, 1'b0, 32'h300, 2, ok);
    check_val("write_while_full", 64'(ok), 64'(1));
    check_val("fifth_stalled", 64'(m0_rd_acc - snap), 64'(0));
    s_bus.readdatavalid = 1'b1;
    s_bus.readdata      = 32'hA0;
    @(negedge clk);
    check_val("first_return", 64'({m1_bus.readdatavalid, m0_bus.readdatavalid, m0_bus.readdata}),
              64'({2'b01, 32'hA0}));
    @(posedge clk);
    #1 s_bus.readdatavalid = 1'b0;
    accepted = 1'b0;
    for (int c = 0; c < 10 && !accepted; c++) begin
      @(negedge clk);
      if (!m0_bus.waitrequest) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    check_val("fifth_accepted", 64'(accepted), 64'(1));
    drive_master(0, 1'b0, 1'b0, 32'h0, 12'h0, 32'h0);
    for (int i = 0; i < RDQ_DEPTH; i++) begin
      s_bus.readdatavalid = 1'b1;
      s_bus.readdata      = 32'hB0 + 32'(i);
      @(negedge clk);
      check_val("drain_route", 64'({m1_bus.readdatavalid, m0_bus.readdatavalid, m0_bus.readdata}),
                64'({2'b01, 32'hB0 + 32'(i)}));
      @(posedge clk);
      #1;
    end
    s_bus.readdatavalid = 1'b0;

    // ---- readdatavalid with the queue empty ----
    @(negedge clk);
    check_val("perr_clear", 64'(protocol_err), 64'(0));
    @(posedge clk);
    #1 s_bus.readdatavalid = 1'b1;
    @(negedge clk);
    check_val("orphan_rdv", 64'({m1_bus.readdatavalid, m0_bus.readdatavalid}), 64'(2'b00));
    @(posedge clk);
    #1 s_bus.readdatavalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("perr_sticky", 64'(protocol_err), 64'(1));
    @(posedge clk);
    #1;

    // ---- asynchronous reset in the middle of a write burst ----
    do_reset();
    @(negedge clk);
    check_val("perr_after_rst", 64'(protocol_err), 64'(0));
    @(posedge clk);
    #1;
    idx = 0;
    for (int c = 0; c < 20 && idx < 2; c++) begin
      drive_master(1, 1'b0, 1'b1, 32'h400, 12'd5, wpat(1, 32'h400, idx));
      @(negedge clk);
      if (!m1_bus.waitrequest) idx++;
      @(posedge clk);
      #1;
    end
    check_val("two_words", 64'(idx), 64'(2));
    rst = 1'b1;
    #1;
    check_val("rst_midburst",
              64'({s_bus.write, grant, m0_bus.waitrequest, m1_bus.waitrequest}),
              64'({1'b0, 2'b00, 1'b1, 1'b1}));
    drive_master(0, 1'b0, 1'b1, 32'h500, 12'd1, wpat(0, 32'h500, 0));
    @(posedge clk);
    #1 rst = 1'b0;
    accepted = 1'b0;
    for (int c = 0; c < 6 && !accepted; c++) begin
      @(negedge clk);
      if (grant != 2'b00) begin
        accepted = 1'b1;
        check_val("post_rst_grant", 64'(grant), 64'(2'b01));
      end
      @(posedge clk);
      #1;
    end
    check_val("post_rst_granted", 64'(accepted), 64'(1));
    bus_idle();
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/avm_burst_arbiter.md
Name: avm_burst_arbiter

Overview:
- Two-master to one-slave Avalon-MM burst arbiter that shares one memory-model burst port between two requesters, e.g. the UUT rx/tx masters and a second VProc master.
- Grants are round-robin and cover a whole burst.
- Outstanding read bursts are tracked in order, so returned read data is steered to the master that issued the burst.
- Sits between the masters and the mem_model rx/tx-style port in the test bench or subsystem.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- BURST_W, 12, burstcount width.
- RDQ_DEPTH, 4, maximum outstanding read bursts; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- mN_address  in  ADDR_W  master N address, N = 0,1.
- mN_burstcount  in  BURST_W  master N burst length.
- mN_read  in  1  master N read request.
- mN_write  in  1  master N write request or write-data valid.
- mN_writedata  in  DATA_W  master N write data.
- mN_waitrequest  out  1  stall to master N.
- mN_readdata  out  DATA_W  read data to master N (copy of s_readdata).
- mN_readdatavalid  out  1  read data valid to master N.
- s_address  out  ADDR_W  slave address.
- s_burstcount  out  BURST_W  slave burst length.
- s_read  out  1  slave read request.
- s_write  out  1  slave write.
- s_writedata  out  DATA_W  slave write data.
- s_waitrequest  in  1  slave stall.
- s_readdata  in  DATA_W  slave read data.
- s_readdatavalid  in  1  slave read data valid.
- grant  out  2  one-hot current grant; 00 when none.
- protocol_err  out  1  sticky error flag.

Behaviour:
- Reset state:
  - state ARB, grant 00, last_grant = 1 so m0 has first priority.
  - Read queue empty; protocol_err 0.
  - mN_waitrequest 1; s_read, s_write, mN_readdatavalid 0.
- Masters obey Avalon rules: command and data held stable while waitrequest = 1.
- A burstcount of 0 is treated as 1 everywhere.

State machine (registered):
- ARB:
  - Eligible master: asserts write, or asserts read while the queue is not full.
  - Winner: the eligible master other than last_grant if it is eligible, else the sole eligible one.
  - Winner is registered into grant, last_grant updated, next state CMD.
  - No eligible master: stay in ARB.
  - All mN_waitrequest = 1 and s_read = s_write = 0 in ARB, so there is a one-cycle arbitration bubble per burst.
- CMD:
  - Granted master's address, burstcount, read, write and writedata pass combinationally to s_*.
  - Granted master's waitrequest = s_waitrequest; the other master's waitrequest = 1.
  - Read: when s_read && !s_waitrequest, push {master id, burstcount} to the queue and return to ARB.
  - Write: a word counter latches burstcount on the first accepted word (s_write && !s_waitrequest).
    - The counter decrements per accepted word.
    - When the last word is accepted, return to ARB; a 1-word burst returns immediately.
  - If the grantee asserts neither read nor write on the first CMD cycle, return to ARB with no transfer.
- grant reads 00 in ARB and the registered one-hot value in CMD.

Read return:
- s_readdata is fanned out to both mN_readdata.
- mN_readdatavalid = s_readdatavalid && queue head id == N, combinational with zero latency.
- A head remaining-count register is loaded from the head burstcount and decremented per valid word.
- On the last word the head is popped.
- A push and a pop in the same cycle are both honoured and the occupancy is unchanged.
- A full queue blocks only reads; writes stay eligible, and in-flight returns continue during write bursts.
- s_readdatavalid with the queue empty: both readdatavalid outputs stay 0 and protocol_err is set.
  - protocol_err stays set until rst.
- Reset mid-operation: state, counters and queue are cleared immediately (asynchronous).
  - Read data returned after reset for pre-reset bursts is flagged via protocol_err.

Test Plan:
- m0 read at 0x100, burstcount 4, slave returns 4 words 0xA0..0xA3 → s_read high 1 cycle; m0_readdatavalid 4 cycles with data 0xA0..0xA3; m1_readdatavalid never asserted; grant 01 then 00.
- After reset, m0 write burst 3 and m1 read burstcount 2 requested in the same cycle → m0 granted first, s_write for 3 words, one ARB bubble, then m1 granted.
  - With both still requesting, grants alternate 01, 10, 01.
- m0 issues 4 reads with the slave withholding data → 5th m0 read stalls (m0_waitrequest 1).
  - m1 write burst 2 is still granted and completes.
  - After the first burst fully returns, the 5th read is accepted.
- Queue holds m1 (count 2) then m0 (count 1); slave returns 3 consecutive valid words → m1 valid on words 1–2, m0 valid on word 3; queue empty afterwards.
- s_readdatavalid pulsed with queue empty → no mN_readdatavalid; protocol_err 1 and held until rst.
- rst asserted after word 2 of an m1 write burst of 5 → s_write 0 immediately; grant 00; mN_waitrequest 1.
  - After rst release, m0 is granted first if both request.
